// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port memory.
// Latency: grant is combinational in the request cycle; the response arrives on the next cycle.
// Backpressure: a requester without a grant holds its request; a starvation counter bounds fetch wait.
module mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_err,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_be,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_err,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       if_win;
  logic       d_win;
  logic       if_bad;
  logic       d_bad;
  logic       if_rvalid_q;
  logic       if_err_q;
  logic       d_rvalid_q;
  logic       d_err_q;
  logic       d_store_q;

  // Pick this cycle's winner and decode the memory command it issues
  always_comb begin
    if_bad      = (i_if_addr[1:0] != 2'b00);
    d_bad       = (i_d_be == 4'b0000) || (i_d_addr[1:0] != 2'b00);
    if_win      = !i_rst && i_if_req && (!i_d_req || (starve_cnt == LIMIT));
    d_win       = !i_rst && i_d_req && !if_win;
    o_mem_read  = (if_win && !if_bad) || (d_win && !d_bad && !i_d_we);
    o_mem_write = d_win && !d_bad && i_d_we;
    o_mem_addr  = if_win ? i_if_addr[ADDR_W-1:2] : i_d_addr[ADDR_W-1:2];
    o_mem_wdata = i_d_wdata;
    o_mem_be    = (d_win && !d_bad && i_d_we) ? i_d_be : 4'b0000;
  end

  assign o_if_gnt = if_win;
  assign o_d_gnt  = d_win;

  // Count consecutive refused fetch cycles; any fetch grant or idle fetch restarts it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= 4'd0;
    end else if (i_if_req && !if_win) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Per-port response registers: one-cycle pulse after each grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_store_q   <= 1'b0;
    end else begin
      if_rvalid_q <= if_win;
      if_err_q    <= if_win && if_bad;
      d_rvalid_q  <= d_win;
      d_err_q     <= d_win && d_bad;
      d_store_q   <= d_win && i_d_we;
    end
  end

  // Memory read data reaches a port only on a successful read response
  always_comb begin
    o_if_rvalid = if_rvalid_q;
    o_if_err    = if_err_q;
    o_d_rvalid  = d_rvalid_q;
    o_d_err     = d_err_q;
    o_if_rdata  = (if_rvalid_q && !if_err_q) ? i_mem_rdata : 32'h0;
    o_d_rdata   = (d_rvalid_q && !d_err_q && !d_store_q) ? i_mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W = 14;
  localparam int LIMIT  = 4;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid, o_if_err;
  logic [31:0]       o_if_rdata;
  logic              i_d_req, i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [31:0]       i_d_wdata;
  logic [3:0]        i_d_be;
  logic              o_d_gnt, o_d_rvalid, o_d_err;
  logic [31:0]       o_d_rdata;
  logic              o_mem_read, o_mem_write;
  logic [ADDR_W-3:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic [31:0]       i_mem_rdata;

  int checks = 0;
  int errors = 0;

  // memory device seen by the DUT, and an independent shadow copy for expectations
  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  // queued expectations: {err, rdata}
  logic [32:0] if_q [$];
  logic [32:0] d_q  [$];
  int refused = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_be(i_d_be), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_d_err(o_d_err), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // memory: byte-enabled write, one-cycle read, garbage on non-read cycles
  always @(posedge clk) begin
    if (o_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    if (o_mem_read) i_mem_rdata <= mem[o_mem_addr];
    else            i_mem_rdata <= $urandom;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor: pop and compare whenever a response is presented
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (o_if_rvalid) begin
        chk("if_rvalid_expected", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          chk("if_err", 32'(o_if_err), 32'(e[32]));
          chk("if_rdata", o_if_rdata, e[31:0]);
        end
      end else begin
        if (if_q.size() != 0) begin
          chk("if_rvalid_missing", 32'(o_if_rvalid), 32'd1);
          void'(if_q.pop_front());
        end
        chk("if_idle_outputs", {o_if_rdata[30:0], o_if_err}, 32'd0);
      end
      if (o_d_rvalid) begin
        chk("d_rvalid_expected", 32'(d_q.size() != 0), 32'd1);
        if (d_q.size() != 0) begin
          e = d_q.pop_front();
          chk("d_err", 32'(o_d_err), 32'(e[32]));
          chk("d_rdata", o_d_rdata, e[31:0]);
        end
      end else begin
        if (d_q.size() != 0) begin
          chk("d_rvalid_missing", 32'(o_d_rvalid), 32'd1);
          void'(d_q.pop_front());
        end
        chk("d_idle_outputs", {o_d_rdata[30:0], o_d_err}, 32'd0);
      end
    end
  end

  // one request cycle: drive, check grants/command against the reference rules, queue responses
  task automatic cycle(input logic fr, input logic [ADDR_W-1:0] fa,
                       input logic dr, input logic dwe, input logic [ADDR_W-1:0] da,
                       input logic [31:0] dwd, input logic [3:0] dbe,
                       output logic fg, output logic dg);
    logic f_ok, d_ok, exp_rd, exp_wr;
    int fw, dw;
    @(negedge clk);
    i_if_req = fr; i_if_addr = fa;
    i_d_req = dr; i_d_we = dwe; i_d_addr = da; i_d_wdata = dwd; i_d_be = dbe;
    #1;
    fg = fr && (!dr || refused == LIMIT);
    dg = dr && !fg;
    f_ok = (fa % 4) == 0;
    d_ok = (dbe != 0) && ((da % 4) == 0);
    fw = int'(fa) / 4;
    dw = int'(da) / 4;
    exp_rd = (fg && f_ok) || (dg && d_ok && !dwe);
    exp_wr = dg && d_ok && dwe;
    chk("if_gnt", 32'(o_if_gnt), 32'(fg));
    chk("d_gnt", 32'(o_d_gnt), 32'(dg));
    chk("mem_read", 32'(o_mem_read), 32'(exp_rd));
    chk("mem_write", 32'(o_mem_write), 32'(exp_wr));
    if (exp_rd || exp_wr) chk("mem_addr", 32'(o_mem_addr), fg ? fw : dw);
    if (exp_wr) begin
      chk("mem_wdata", o_mem_wdata, dwd);
      chk("mem_be", 32'(o_mem_be), 32'(dbe));
    end
    if (exp_rd) chk("mem_be_read", 32'(o_mem_be), 32'd0);
    if (fg) if_q.push_back(f_ok ? {1'b0, ref_mem[fw]} : {1'b1, 32'h0});
    if (dg) begin
      if (exp_wr)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[dw][8*b +: 8] = dwd[8*b +: 8];
      if (!d_ok)      d_q.push_back({1'b1, 32'h0});
      else if (dwe)   d_q.push_back({1'b0, 32'h0});
      else            d_q.push_back({1'b0, ref_mem[dw]});
    end
    refused = (fr && !fg) ? ((refused == LIMIT) ? refused : refused + 1) : 0;
  endtask

  task automatic idle();
    logic fg, dg;
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
  endtask

  initial begin
    logic fg, dg, fr, dr, dwe;
    logic [ADDR_W-1:0] fa, da;
    logic [31:0] dwd;
    logic [3:0] dbe;

    for (int i = 0; i < WORDS; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
    mem[4] = 32'h0;        ref_mem[4] = 32'h0;

    // reset with both requests high: nothing granted, outputs quiet
    i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = '0; i_d_req = 1'b1; i_d_we = 1'b1;
    i_d_addr = '0; i_d_wdata = 32'h0; i_d_be = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_gnts", {o_if_gnt, o_d_gnt}, 32'd0);
    chk("rst_mem_strobes", {o_mem_read, o_mem_write}, 32'd0);
    chk("rst_rvalid_err", {o_if_rvalid, o_d_rvalid, o_if_err, o_d_err}, 32'd0);
    chk("rst_rdata", o_if_rdata | o_d_rdata, 32'd0);
    i_if_req = 1'b0; i_d_req = 1'b0; i_rst = 1'b0;

    // fetch alone from word 1
    cycle(1'b1, 14'h0004, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
    chk("fetch_alone_addr", 32'(o_mem_addr), 32'd1);
    idle();
    // store then load
    cycle(1'b0, '0, 1'b1, 1'b1, 14'h0010, 32'h12345678, 4'b0011, fg, dg);
    cycle(1'b0, '0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF, fg, dg);
    idle();
    chk("store_load_ref", ref_mem[4], 32'h00005678);
    // error responses
    cycle(1'b1, 14'h0002, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
    cycle(1'b0, '0, 1'b1, 1'b1, 14'h0020, 32'hFFFFFFFF, 4'h0, fg, dg);
    cycle(1'b0, '0, 1'b1, 1'b0, 14'h0021, 32'h0, 4'hF, fg, dg);
    idle();
    // pipelined fetches
    cycle(1'b1, 14'h0000, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
    cycle(1'b1, 14'h0004, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
    cycle(1'b1, 14'h0008, 1'b0, 1'b0, '0, 32'h0, 4'h0, fg, dg);
    idle();

    // build up starvation, then reset right after a granted store
    cycle(1'b1, 14'h0040, 1'b1, 1'b0, 14'h0044, 32'h0, 4'hF, fg, dg);
    cycle(1'b1, 14'h0040, 1'b1, 1'b0, 14'h0044, 32'h0, 4'hF, fg, dg);
    cycle(1'b1, 14'h0040, 1'b1, 1'b1, 14'h0048, 32'hCAFEF00D, 4'hF, fg, dg);
    chk("prereset_store_gnt", 32'(o_d_gnt), 32'd1);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_rvalid", {o_if_rvalid, o_d_rvalid}, 32'd0);
    chk("async_rst_outputs", o_d_rdata | o_if_rdata | 32'({o_if_err, o_d_err}), 32'd0);
    chk("async_rst_gnts", {o_if_gnt, o_d_gnt}, 32'd0);
    if_q.delete(); d_q.delete();
    refused = 0;
    repeat (3) @(negedge clk);
    i_if_req = 1'b0; i_d_req = 1'b0; i_rst = 1'b0;

    // continuous conflict: fetch wins every STARVE_LIMIT+1 cycles, counting from reset
    for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
      cycle(1'b1, 14'h0010, 1'b1, 1'b0, 14'h0014, 32'h0, 4'hF, fg, dg);
      chk("conflict_fetch_win", 32'(fg), 32'((i % (LIMIT + 1)) == LIMIT));
    end
    idle();

    // randomized traffic with requests held until granted
    fr = 1'b0; dr = 1'b0; fa = '0; da = '0; dwe = 1'b0; dwd = 32'h0; dbe = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if (!fr && $urandom_range(0, 2) != 0) begin
        fr = 1'b1;
        fa = 14'($urandom_range(0, 127));
        if ($urandom_range(0, 5) != 0) fa[1:0] = 2'b00;
      end
      if (!dr && $urandom_range(0, 3) != 0) begin
        dr = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        da = 14'($urandom_range(0, 127));
        if ($urandom_range(0, 5) != 0) da[1:0] = 2'b00;
        dwd = $urandom;
        dbe = 4'($urandom_range(0, 15));
      end
      cycle(fr, fa, dr, dwe, da, dwd, dbe, fg, dg);
      if (fg) fr = 1'b0;
      if (dg) dr = 1'b0;
    end
    idle();
    idle();
    chk("queues_drained", 32'(if_q.size() + d_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop so the bench can never hang
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the CPU instruction-fetch path and the load/store data path. Sits between the `cpu` core and `memory`, and owns every memory command: read enable, write enable, address, write data and byte enables. Grants at most one access per cycle and returns read data with a fixed one-cycle latency. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- ADDR_W, 14, byte-address width on both requester ports; memory word address is ADDR_W-2 bits
- STARVE_LIMIT, 4, consecutive refused fetch-request cycles after which fetch wins the next conflict (1..15)

Ports (clock and reset first). Reset is asynchronous and active-high.
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch request
- i_if_addr  in  ADDR_W  fetch byte address
- o_if_gnt  out  1  fetch accepted this cycle (combinational)
- o_if_rvalid  out  1  fetch response valid
- o_if_rdata  out  32  fetch read data
- o_if_err  out  1  fetch response is an alignment error
- i_d_req  in  1  data request
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  ADDR_W  data byte address
- i_d_wdata  in  32  store data
- i_d_be  in  4  byte enables
- o_d_gnt  out  1  data accepted this cycle (combinational)
- o_d_rvalid  out  1  data response valid, for loads and stores
- o_d_rdata  out  32  load data; 0 for store responses
- o_d_err  out  1  data response is an error
- o_mem_read  out  1  memory read strobe
- o_mem_write  out  1  memory write strobe
- o_mem_addr  out  ADDR_W-2  word address, taken from the winner's addr[ADDR_W-1:2]
- o_mem_wdata  out  32  write data
- o_mem_be  out  4  write byte enables
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_read

## Operation
- Arbitration is combinational in the request cycle.
  - Only one request: it is granted.
  - Both requests: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - While i_rst is high, no grants.
- A request is held by its requester until it sees gnt; requester fields must stay stable while req is high.
- Granted fetch:
  - addr[1:0] != 0: error; no memory command issued.
  - Otherwise o_mem_read = 1 with the fetch address.
- Granted data:
  - i_d_be == 0, or addr[1:0] != 0: error; no memory command issued.
  - Otherwise a load drives o_mem_read, a store drives o_mem_write with wdata and be.
  - o_mem_be = 0 on reads.
- Idle cycles (no grant): o_mem_read = o_mem_write = 0. Address, wdata and be are don't-care.
- Response register, one per port: rvalid, err, is_store.
  - Set on the edge after the grant; cleared otherwise.
  - Ports are independent.
- Read data paths:
  - o_if_rdata = i_mem_rdata, passed through, while o_if_rvalid is high and err is clear; otherwise 0.
  - o_d_rdata = i_mem_rdata for a successful load; otherwise 0.
- Starve counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each cycle with i_if_req high and o_if_gnt low.
  - Clears on a fetch grant or when i_if_req is low.

## Timing
- Reset values: all rvalid/err outputs 0, rdata outputs 0, starve_cnt 0. o_mem_read/o_mem_write are 0 during reset.
- Reset asserted mid-operation discards any pending response; no rvalid appears after reset releases.
- Latency: grant in cycle N leads to rvalid in cycle N+1. Error responses have the same latency.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants produce back-to-back rvalids.
- Alternating ports: in the same cycle, one port may show rvalid while the other receives a grant.
- Worst-case fetch wait under continuous data requests: STARVE_LIMIT+1 cycles from request to grant.
- Fetch then re-starves: after a fetch win, starve_cnt restarts from 0.

## Test plan
- Fetch alone: i_if_req = 1, i_if_addr = 0x0004, memory word 1 = 0xDEADBEEF.
  - Response: o_if_gnt = 1 and o_mem_addr = 1 in the same cycle.
  - Next cycle: o_if_rvalid = 1, o_if_rdata = 0xDEADBEEF, o_if_err = 0.
- Store then load: store wdata 0x12345678, be = 4'b0011, addr 0x0010, then a load of addr 0x0010 with the word previously 0.
  - Store: o_d_rvalid = 1, o_d_rdata = 0.
  - Load returns 0x00005678.
- Conflict with STARVE_LIMIT = 4: i_if_req and i_d_req held high continuously.
  - Data granted cycles 0-3; fetch granted cycle 4; data granted cycles 5-8; fetch granted cycle 9.
- Errors:
  - Fetch addr 0x0002: o_if_err = 1 next cycle, no o_mem_read.
  - Data be = 0: o_d_err = 1, no o_mem_write.
- Async reset: assert i_rst mid-cycle right after a grant.
  - Outputs clear immediately; no rvalid on the following edges; starve_cnt = 0.
- Pipelined reads: fetch requests at addr 0, 4, 8 on consecutive cycles.
  - Three consecutive o_if_rvalid cycles with the matching words.
